led_rate_scheduler: RTL and testbench

- Single-clock controller that sequences a 4-bit LED counter through four blink rates.
- The four rates are derived from one clock with a shared prescaler: step periods of 2 s, 1 s, 0.5 s and 0.25 s at defaults.
- Rate is chosen by debounced one-hot switches (MANUAL), or rotated automatically after a fixed number of steps (AUTO).
- A debounced mode button toggles between MANUAL and AUTO. The block sits between board switches/button and the LEDs.

---
 rtl/led_rate_scheduler.sv | 253 +++++++++++++++++++++++++
 tb/tb_led_rate_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_rate_scheduler.sv
// LED rate scheduler: steps a 4-bit LED counter at one of four blink rates.
// The rate comes from debounced one-hot switches (MANUAL) or rotates after a
// fixed number of steps (AUTO). A debounced button toggles between the two.

// Two-flop synchroniser followed by a consecutive-sample debouncer.
module led_rate_debounce #(
  parameter int W          = 1,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic         clock,
  input  logic         n_reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  // The sample that reaches DEB_CYCLES-1 is the one that also loads stable.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 2);

  logic [W-1:0]  meta_r, sync_r, prev_r, stable_r, stable_n;
  logic [CW-1:0] cnt_r, cnt_n;

  // Count consecutive agreeing samples that differ from the accepted value.
  always_comb begin
    stable_n = stable_r;
    cnt_n    = {CW{1'b0}};
    if ((sync_r == stable_r) || (sync_r != prev_r)) begin
      cnt_n = {CW{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      stable_n = sync_r;
      cnt_n    = {CW{1'b0}};
    end else begin
      cnt_n = cnt_r + CW'(1'b1);
    end
  end

  // Synchroniser chain, previous-sample register and debounce state.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      meta_r   <= {W{1'b0}};
      sync_r   <= {W{1'b0}};
      prev_r   <= {W{1'b0}};
      stable_r <= {W{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else begin
      meta_r   <= din;
      sync_r   <= meta_r;
      prev_r   <= sync_r;
      stable_r <= stable_n;
      cnt_r    <= cnt_n;
    end
  end

  assign dout = stable_r;
endmodule

module led_rate_scheduler #(
  parameter int TICK_DIV   = 12500000,
  parameter int DEB_CYCLES = 1000000,
  parameter int DWELL      = 8
) (
  input  logic       clock,
  input  logic       n_reset,
  input  logic [3:0] sw,
  input  logic       btn_mode,
  output logic [3:0] led,
  output logic [1:0] rate_sel,
  output logic       auto_mode,
  output logic       active,
  output logic       step
);
  localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DWW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [PW-1:0]  TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [DWW-1:0] DWELL_LAST = DWW'(DWELL - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MANUAL = 2'd1, AUTO = 2'd2} state_t;

  function automatic logic is_onehot4(input logic [3:0] v);
    case (v)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: is_onehot4 = 1'b1;
      default:                            is_onehot4 = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] onehot_index(input logic [3:0] v);
    case (v)
      4'b0010: onehot_index = 2'd1;
      4'b0100: onehot_index = 2'd2;
      4'b1000: onehot_index = 2'd3;
      default: onehot_index = 2'd0;
    endcase
  endfunction

  logic [3:0]     sw_stable_s;
  logic           btn_stable_s, btn_stable_d_r, mode_evt_s;
  logic           sw_onehot_s, tick_s, qual_s;
  logic [1:0]     sw_idx_s;
  state_t         state_r, state_n;
  logic [3:0]     led_r, led_n;
  logic [1:0]     rate_r, rate_n;
  logic [2:0]     phase_r, phase_n;
  logic [PW-1:0]  pre_r, pre_n;
  logic [DWW-1:0] dwell_r, dwell_n;
  logic           step_r, step_n, auto_r, auto_n, active_r, active_n;

  led_rate_debounce #(.W(4), .DEB_CYCLES(DEB_CYCLES)) u_sw_deb (
    .clock(clock), .n_reset(n_reset), .din(sw), .dout(sw_stable_s)
  );
  led_rate_debounce #(.W(1), .DEB_CYCLES(DEB_CYCLES)) u_btn_deb (
    .clock(clock), .n_reset(n_reset), .din(btn_mode), .dout(btn_stable_s)
  );

  assign mode_evt_s  = btn_stable_s & ~btn_stable_d_r;
  assign sw_onehot_s = is_onehot4(sw_stable_s);
  assign sw_idx_s    = onehot_index(sw_stable_s);
  assign tick_s      = (pre_r == TICK_LAST);

  // A tick produces a step only on the phases belonging to the current rate.
  always_comb begin
    qual_s = 1'b0;
    case (rate_r)
      2'd3:    qual_s = 1'b1;
      2'd2:    qual_s = phase_r[0];
      2'd1:    qual_s = &phase_r[1:0];
      default: qual_s = &phase_r;
    endcase
  end

  // Next state and datapath; mode event beats switch change beats step.
  always_comb begin
    state_n = state_r;
    led_n   = led_r;
    rate_n  = rate_r;
    dwell_n = dwell_r;
    step_n  = 1'b0;
    if (tick_s) begin
      pre_n   = {PW{1'b0}};
      phase_n = phase_r + 3'd1;
    end else begin
      pre_n   = pre_r + PW'(1'b1);
      phase_n = phase_r;
    end
    case (state_r)
      IDLE: begin
        led_n   = 4'd0;
        rate_n  = 2'd0;
        dwell_n = {DWW{1'b0}};
        phase_n = 3'd0;
        if (mode_evt_s) begin
          state_n = AUTO;
          pre_n   = {PW{1'b0}};
        end else if (sw_onehot_s) begin
          state_n = MANUAL;
          rate_n  = sw_idx_s;
        end else begin
          state_n = IDLE;
        end
      end
      MANUAL: begin
        if (mode_evt_s) begin
          state_n = AUTO;
          led_n   = 4'd0;
          rate_n  = 2'd0;
          phase_n = 3'd0;
          pre_n   = {PW{1'b0}};
          dwell_n = {DWW{1'b0}};
        end else if (!sw_onehot_s) begin
          state_n = IDLE;
          led_n   = 4'd0;
          rate_n  = 2'd0;
          phase_n = 3'd0;
        end else if (sw_idx_s != rate_r) begin
          led_n   = 4'd0;
          rate_n  = sw_idx_s;
          phase_n = 3'd0;
          pre_n   = {PW{1'b0}};
        end else if (tick_s && qual_s) begin
          step_n = 1'b1;
          led_n  = led_r + 4'd1;
        end else begin
          state_n = MANUAL;
        end
      end
      AUTO: begin
        if (mode_evt_s) begin
          led_n   = 4'd0;
          dwell_n = {DWW{1'b0}};
          if (sw_onehot_s) begin
            state_n = MANUAL;
            rate_n  = sw_idx_s;
          end else begin
            state_n = IDLE;
            rate_n  = 2'd0;
            phase_n = 3'd0;
          end
        end else if (tick_s && qual_s) begin
          step_n = 1'b1;
          led_n  = led_r + 4'd1;
          if (dwell_r == DWELL_LAST) begin
            dwell_n = {DWW{1'b0}};
            rate_n  = rate_r + 2'd1;
          end else begin
            dwell_n = dwell_r + DWW'(1'b1);
          end
        end else begin
          state_n = AUTO;
        end
      end
      default: begin
        state_n = IDLE;
        led_n   = 4'd0;
        rate_n  = 2'd0;
        phase_n = 3'd0;
        dwell_n = {DWW{1'b0}};
      end
    endcase
    auto_n   = (state_n == AUTO);
    active_n = (state_n != IDLE);
  end

  // State register plus registered outputs and the button edge history.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_r        <= IDLE;
      led_r          <= 4'd0;
      rate_r         <= 2'd0;
      phase_r        <= 3'd0;
      pre_r          <= {PW{1'b0}};
      dwell_r        <= {DWW{1'b0}};
      step_r         <= 1'b0;
      auto_r         <= 1'b0;
      active_r       <= 1'b0;
      btn_stable_d_r <= 1'b0;
    end else begin
      state_r        <= state_n;
      led_r          <= led_n;
      rate_r         <= rate_n;
      phase_r        <= phase_n;
      pre_r          <= pre_n;
      dwell_r        <= dwell_n;
      step_r         <= step_n;
      auto_r         <= auto_n;
      active_r       <= active_n;
      btn_stable_d_r <= btn_stable_s;
    end
  end

  assign led       = led_r;
  assign rate_sel  = rate_r;
  assign auto_mode = auto_r;
  assign active    = active_r;
  assign step      = step_r;
endmodule

// File: tb/tb_led_rate_scheduler.sv
// Bench for led_rate_scheduler with TICK_DIV=4, DEB_CYCLES=3, DWELL=2.
module tb_led_rate_scheduler;
  logic       clock = 1'b0;
  logic       n_reset;
  logic [3:0] sw;
  logic       btn_mode;
  logic [3:0] led;
  logic [1:0] rate_sel;
  logic       auto_mode, active, step;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_step = 0;

  typedef struct { logic [3:0] led; logic [1:0] rate; int gap; } step_exp_t;
  typedef struct { logic [3:0] sw; logic active; logic [1:0] rate; } sel_vec_t;

  step_exp_t exp_q[$];
  step_exp_t auto_tab[8];
  sel_vec_t  sel_tab[5];

  led_rate_scheduler #(.TICK_DIV(4), .DEB_CYCLES(3), .DWELL(2)) dut (
    .clock(clock), .n_reset(n_reset), .sw(sw), .btn_mode(btn_mode),
    .led(led), .rate_sel(rate_sel), .auto_mode(auto_mode),
    .active(active), .step(step)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_out(input string name, input int act_active, input int act_auto,
                         input int exp_rate, input int exp_led);
    chk({name, "_active"}, int'(active), act_active);
    chk({name, "_auto"}, int'(auto_mode), act_auto);
    chk({name, "_rate"}, int'(rate_sel), exp_rate);
    chk({name, "_led"}, int'(led), exp_led);
  endtask

  task automatic nedge(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic push(input int l, input int r, input int gap);
    step_exp_t e;
    e.led = 4'(l);
    e.rate = 2'(r);
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Scoreboard: every step pulse pops one expected record.
  initial begin
    step_exp_t e;
    forever begin
      @(negedge clock);
      cyc = cyc + 1;
      if (step === 1'b1) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("step_led", int'(led), int'(e.led));
          chk("step_rate", int'(rate_sel), int'(e.rate));
          if (e.gap != 0) chk("step_gap", cyc - last_step, e.gap);
        end else begin
          chk("step_unexpected", 1, 0);
        end
        last_step = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    sel_tab[0] = '{4'b0011, 1'b0, 2'd0};
    sel_tab[1] = '{4'b0010, 1'b1, 2'd1};
    sel_tab[2] = '{4'b0001, 1'b1, 2'd0};
    sel_tab[3] = '{4'b0110, 1'b0, 2'd0};
    sel_tab[4] = '{4'b0000, 1'b0, 2'd0};
    auto_tab[0] = '{4'd1, 2'd0, 0};
    auto_tab[1] = '{4'd2, 2'd1, 32};
    auto_tab[2] = '{4'd3, 2'd1, 16};
    auto_tab[3] = '{4'd4, 2'd2, 16};
    auto_tab[4] = '{4'd5, 2'd2, 8};
    auto_tab[5] = '{4'd6, 2'd3, 8};
    auto_tab[6] = '{4'd7, 2'd3, 4};
    auto_tab[7] = '{4'd8, 2'd0, 4};

    n_reset = 1'b0;
    sw = 4'b0000;
    btn_mode = 1'b0;
    nedge(3);
    chk_out("reset", 0, 0, 0, 0);
    chk("reset_step", int'(step), 0);
    n_reset = 1'b1;
    nedge(2);
    chk_out("idle", 0, 0, 0, 0);

    // Switch selection table: state held for 5 cycles, changed on the 6th.
    begin
      int pa = 0;
      int pr = 0;
      for (int i = 0; i < 5; i++) begin
        sw = sel_tab[i].sw;
        nedge(5);
        chk("sel_hold_active", int'(active), pa);
        chk("sel_hold_rate", int'(rate_sel), pr);
        nedge(1);
        chk_out("sel_new", int'(sel_tab[i].active), 0, int'(sel_tab[i].rate), 0);
        nedge(2);
        pa = int'(sel_tab[i].active);
        pr = int'(sel_tab[i].rate);
      end
    end

    // MANUAL slow rate: 32-cycle steps, led wraps 15->0, continue to 3.
    sw = 4'b0001;
    nedge(5);
    chk("slow_latency_active", int'(active), 0);
    nedge(1);
    chk_out("slow_entry", 1, 0, 0, 0);
    for (int i = 0; i < 19; i++) push((i + 1) % 16, 0, (i == 0) ? 0 : 32);
    wait_empty("slow", 19 * 32 + 64);

    // Rate change to 3 while led=3.
    sw = 4'b1000;
    nedge(6);
    chk_out("rate3_entry", 1, 0, 3, 0);
    push(1, 3, 0);
    push(2, 3, 4);
    push(3, 3, 4);
    push(4, 3, 4);
    nedge(3);
    chk("rate3_first_wait", int'(led), 0);
    nedge(1);
    chk("rate3_first_step", int'(led), 1);
    wait_empty("rate3", 40);

    // Two-cycle glitch must be ignored while steps keep running.
    push(5, 3, 4);
    push(6, 3, 4);
    push(7, 3, 4);
    sw = 4'b0100;
    nedge(2);
    sw = 4'b1000;
    wait_empty("glitch", 40);
    chk_out("glitch_after", 1, 0, 3, 7);

    // Same change held long enough is accepted.
    push(8, 3, 4);
    sw = 4'b0100;
    nedge(6);
    chk_out("rate2_entry", 1, 0, 2, 0);
    push(1, 2, 0);
    push(2, 2, 8);
    wait_empty("rate2", 40);

    // Multi-hot select drops to IDLE with no steps.
    sw = 4'b0011;
    nedge(6);
    chk_out("invalid", 0, 0, 0, 0);
    nedge(40);
    chk_out("invalid_hold", 0, 0, 0, 0);
    sw = 4'b0010;
    nedge(6);
    chk_out("rate1_entry", 1, 0, 1, 0);
    push(1, 1, 0);
    push(2, 1, 16);
    wait_empty("rate1", 60);

    // Button press enters AUTO; rates rotate every two steps.
    btn_mode = 1'b1;
    nedge(4);
    btn_mode = 1'b0;
    nedge(2);
    chk_out("auto_entry", 1, 1, 0, 0);
    for (int i = 0; i < 8; i++) exp_q.push_back(auto_tab[i]);
    wait_empty("auto", 8 * 40 + 40);

    // Mode event lands on the same edge as the next rate-0 step.
    nedge(2);
    btn_mode = 1'b1;
    nedge(4);
    btn_mode = 1'b0;
    nedge(2);
    chk_out("coincide", 1, 0, 1, 0);
    chk("coincide_step", int'(step), 0);
    push(1, 1, 0);
    wait_empty("after_coincide", 40);

    // Back to AUTO, then reset mid-count with led=5.
    btn_mode = 1'b1;
    nedge(4);
    btn_mode = 1'b0;
    nedge(2);
    chk_out("auto2_entry", 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) exp_q.push_back(auto_tab[i]);
    wait_empty("auto2", 5 * 40 + 40);
    chk_out("pre_reset", 1, 1, 2, 5);
    nedge(3);
    n_reset = 1'b0;
    #1;
    chk_out("async_reset", 0, 0, 0, 0);
    chk("async_reset_step", int'(step), 0);
    nedge(2);
    chk_out("reset_hold", 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
